// File: rtl/i2s_pkg.sv
// Definitions shared by the I2S transceiver, the DSP stages and the tx buffer.
package i2s_pkg;

  localparam int I2S_SAMPLE_BITS = 16;

  typedef struct packed {
    logic signed [I2S_SAMPLE_BITS-1:0] left;
    logic signed [I2S_SAMPLE_BITS-1:0] right;
  } i2s_frame_t;

endpackage

// File: rtl/sync_frame_fifo.sv
// Single-clock frame FIFO with explicit level counter, flush and a
// combinational head read. Callers never push when full or pop when empty.
module sync_frame_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_flush,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic [WIDTH-1:0]       i_data,
  output logic [WIDTH-1:0]       o_head,
  output logic [$clog2(DEPTH):0] o_level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;

  // Storage needs no reset: the level counter gates every use of the head.
  always_ff @(posedge i_clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_level  <= {(AW+1){1'b0}};
    end else begin
      if (i_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({i_push, i_pop})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_level = r_level;

endmodule

// File: rtl/i2s_tx_buffer.sv
// Stereo tx buffer in front of the I2S transceiver: primes to a threshold,
// then streams frames, substituting silence and counting underruns.
module i2s_tx_buffer
  import i2s_pkg::*;
#(
  parameter int SAMPLE_BITS = I2S_SAMPLE_BITS,
  parameter int DEPTH       = 16,
  parameter int PRIME_LEVEL = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [SAMPLE_BITS-1:0]   in_sample_l,
  input  logic [SAMPLE_BITS-1:0]   in_sample_r,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [SAMPLE_BITS-1:0]   out_sample_l,
  output logic [SAMPLE_BITS-1:0]   out_sample_r,
  output logic                     out_valid,
  input  logic                     out_ready,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   level,
  output logic [15:0]              underrun_count
);

  localparam int LW = $clog2(DEPTH) + 1;

  typedef enum logic {
    ST_PRIMING = 1'b0,
    ST_RUNNING = 1'b1
  } state_t;

  state_t                   r_state;
  state_t                   w_state_next;
  logic                     r_out_valid;
  logic [15:0]              r_underrun_count;
  logic [LW-1:0]            w_level;
  logic [2*SAMPLE_BITS-1:0] w_head;
  logic                     w_push;
  logic                     w_pop;
  logic                     w_handshake;
  logic                     w_underrun;
  logic                     w_nonempty;
  logic [SAMPLE_BITS-1:0]   w_out_l;
  logic [SAMPLE_BITS-1:0]   w_out_r;

  assign in_ready    = !rst && !flush && (w_level != LW'(DEPTH));
  assign w_push      = in_valid && in_ready;
  assign w_nonempty  = (w_level != {LW{1'b0}});
  // Flush outranks any handshake in the same cycle.
  assign w_handshake = r_out_valid && out_ready && !flush;
  assign w_pop       = (r_state == ST_RUNNING) && w_nonempty && w_handshake;
  assign w_underrun  = (r_state == ST_RUNNING) && !w_nonempty && w_handshake;

  sync_frame_fifo #(
    .WIDTH (2*SAMPLE_BITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_flush (flush),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  ({in_sample_l, in_sample_r}),
    .o_head  (w_head),
    .o_level (w_level)
  );

  always_comb begin
    w_state_next = r_state;
    w_out_l      = {SAMPLE_BITS{1'b0}};
    w_out_r      = {SAMPLE_BITS{1'b0}};
    case (r_state)
      ST_PRIMING: begin
        if (w_level >= LW'(PRIME_LEVEL)) begin
          w_state_next = ST_RUNNING;
        end else begin
          w_state_next = ST_PRIMING;
        end
      end
      ST_RUNNING: begin
        if (w_underrun) begin
          w_state_next = ST_PRIMING;
        end else begin
          w_state_next = ST_RUNNING;
        end
        if (w_nonempty) begin
          w_out_l = w_head[2*SAMPLE_BITS-1:SAMPLE_BITS];
          w_out_r = w_head[SAMPLE_BITS-1:0];
        end else begin
          w_out_l = {SAMPLE_BITS{1'b0}};
          w_out_r = {SAMPLE_BITS{1'b0}};
        end
      end
      default: w_state_next = ST_PRIMING;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_state <= ST_PRIMING;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid      <= 1'b0;
      r_underrun_count <= 16'h0000;
    end else begin
      r_out_valid <= 1'b1;
      if (w_underrun && (r_underrun_count != 16'hFFFF)) begin
        r_underrun_count <= r_underrun_count + 16'h0001;
      end else begin
        r_underrun_count <= r_underrun_count;
      end
    end
  end

  assign out_sample_l   = w_out_l;
  assign out_sample_r   = w_out_r;
  assign out_valid      = r_out_valid;
  assign level          = w_level;
  assign underrun_count = r_underrun_count;

endmodule

// File: tb/tb_i2s_tx_buffer.sv
// Scoreboard bench for i2s_tx_buffer: accepted frames are queued as expected
// output, and a negedge monitor checks every output against a frame-level model.
module tb_i2s_tx_buffer;

  localparam int SB    = 16;
  localparam int DEPTH = 16;
  localparam int PRIME = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [SB-1:0] in_l, in_r;
  logic          in_valid, in_ready;
  logic [SB-1:0] out_l, out_r;
  logic          out_valid, out_ready, flush;
  logic [LW-1:0] level;
  logic [15:0]   ucount;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: frames held, primed/running flag, output-valid flag, count.
  logic [2*SB-1:0] m_q[$];
  bit              m_running = 1'b0;
  bit              m_ov      = 1'b0;
  logic [15:0]     m_cnt     = 16'h0000;
  bit              load_cnt  = 1'b0;

  i2s_tx_buffer #(.SAMPLE_BITS(SB), .DEPTH(DEPTH), .PRIME_LEVEL(PRIME)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_sample_l    (in_l),
    .in_sample_r    (in_r),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .out_sample_l   (out_l),
    .out_sample_r   (out_r),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .flush          (flush),
    .level          (level),
    .underrun_count (ucount)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare outputs with the model, then advance the model across the next edge.
  always @(negedge clk) begin
    bit          exp_rdy, hs, accept;
    logic [SB-1:0] exp_l, exp_r;
    if (load_cnt) m_cnt = 16'hFFFD;
    exp_rdy = !rst && !flush && (m_q.size() != DEPTH);
    exp_l = '0;
    exp_r = '0;
    if (m_running && m_q.size() > 0) begin
      exp_l = m_q[0][2*SB-1:SB];
      exp_r = m_q[0][SB-1:0];
    end
    check("in_ready",       32'(in_ready),  32'(exp_rdy));
    check("out_valid",      32'(out_valid), 32'(m_ov));
    check("out_sample_l",   32'(out_l),     32'(exp_l));
    check("out_sample_r",   32'(out_r),     32'(exp_r));
    check("level",          32'(level),     32'(m_q.size()));
    check("underrun_count", 32'(ucount),    32'(m_cnt));

    if (rst) begin
      m_q.delete();
      m_running = 1'b0;
      m_cnt     = 16'h0000;
      m_ov      = 1'b0;
    end else begin
      hs = m_ov && out_ready;
      if (flush) begin
        m_q.delete();
        m_running = 1'b0;
      end else begin
        accept = in_valid && exp_rdy;
        if (!m_running) begin
          if (m_q.size() >= PRIME) m_running = 1'b1;
        end else if (hs) begin
          if (m_q.size() > 0) begin
            void'(m_q.pop_front());
          end else begin
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'h0001;
            m_running = 1'b0;
          end
        end
        if (accept) m_q.push_back({in_l, in_r});
      end
      m_ov = 1'b1;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_frame();
    in_l = SB'($urandom);
    in_r = SB'($urandom);
  endtask

  // Prime four frames while stalled, then drain through to one underrun.
  task automatic do_underrun();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < PRIME; i++) begin
      rand_frame();
      cyc();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) cyc();
  endtask

  initial begin
    int n;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_l = '0; in_r = '0;
    for (int i = 0; i < 3; i++) cyc();
    rst = 1'b0;
    cyc();

    // Four known frames, then drain into an underrun.
    out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      in_valid = 1'b1;
      in_l = SB'(k);
      in_r = SB'(-k);
      cyc();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 12; i++) cyc();

    // Overfill while stalled: only DEPTH frames accepted.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      rand_frame();
      cyc();
    end
    in_valid = 1'b0;
    cyc();

    // Drain to five, then push and pop together across the pointer wrap.
    out_ready = 1'b1;
    n = 0;
    while (m_q.size() != 5 && n < 40) begin
      cyc();
      n++;
    end
    check("drain_to_5_timeout", 32'(n < 40), 32'd1);
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      rand_frame();
      cyc();
    end

    // Fill to nine, then flush with a frame offered.
    out_ready = 1'b0;
    n = 0;
    while (m_q.size() != 9 && n < 40) begin
      rand_frame();
      cyc();
      n++;
    end
    check("fill_to_9_timeout", 32'(n < 40), 32'd1);
    flush = 1'b1;
    rand_frame();
    cyc();
    flush = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) cyc();

    // Reset mid-stream.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rand_frame();
      cyc();
    end
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;

    // Random traffic in segments of differing producer/consumer bias.
    for (int seg = 0; seg < 6; seg++) begin
      int pv, pr;
      pv = 20 + 15 * seg;
      pr = 95 - 15 * seg;
      for (int i = 0; i < 400; i++) begin
        in_valid  = ($urandom_range(0, 99) < pv);
        out_ready = ($urandom_range(0, 99) < pr);
        flush     = ($urandom_range(0, 63) == 0);
        rst       = ($urandom_range(0, 255) == 0);
        rand_frame();
        cyc();
      end
    end
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;

    // Saturation: two natural underruns, then jump near the top and exceed it.
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    do_underrun();
    do_underrun();
    out_ready = 1'b0;
    force dut.r_underrun_count = 16'hFFFD;
    load_cnt = 1'b1;
    cyc();
    release dut.r_underrun_count;
    cyc();
    load_cnt = 1'b0;
    for (int i = 0; i < 4; i++) do_underrun();
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
